// File: rtl/riscv_mem_pkg.sv
// Shared encodings and helpers for the memory pipeline stage: access sizes,
// LSU state names and the size/alignment/legality rules.
package riscv_mem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_D  = 3'b011,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101,
        MEM_WU = 3'b110
    } mem_size_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_e;

    // One bit per byte touched by the access, anchored at lane 0.
    function automatic logic [7:0] size_mask(input logic [2:0] funct3);
        case (funct3)
            MEM_B, MEM_BU: return 8'h01;
            MEM_H, MEM_HU: return 8'h03;
            MEM_W, MEM_WU: return 8'h0F;
            MEM_D:         return 8'hFF;
            default:       return 8'h00;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [2:0] funct3, input logic [2:0] addr,
                                        input int xlen);
        case (funct3)
            MEM_B, MEM_BU: return 1'b1;
            MEM_H, MEM_HU: return ~addr[0];
            MEM_W, MEM_WU: return addr[1:0] == 2'b00;
            MEM_D:         return (addr == 3'b000) && (xlen >= 64);
            default:       return 1'b0;
        endcase
    endfunction

    // Stores have no unsigned forms; doubleword and LWU exist only on RV64.
    function automatic logic is_legal(input logic [2:0] funct3, input logic isStore,
                                      input int xlen);
        if (isStore) begin
            case (funct3)
                MEM_B, MEM_H, MEM_W: return 1'b1;
                MEM_D:               return xlen == 64;
                default:             return 1'b0;
            endcase
        end else begin
            case (funct3)
                MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: return 1'b1;
                MEM_D, MEM_WU:                       return xlen == 64;
                default:                             return 1'b0;
            endcase
        end
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte enables and data replication on
// the way out, load shift and sign/zero extension on the way back.
module mem_lane_align
    import riscv_mem_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  logic [2:0]      storeFunct3,
    input  logic [OFFW-1:0] storeOffset,
    input  logic            isStore,
    input  logic [XLEN-1:0] storeData,
    output logic [NB-1:0]   byteEn,
    output logic [XLEN-1:0] wData,
    input  logic [2:0]      loadFunct3,
    input  logic [OFFW-1:0] loadOffset,
    input  logic [XLEN-1:0] readData,
    output logic [XLEN-1:0] loadData
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        byteEn = '1;
        if (isStore) begin
            byteEn = NB'(size_mask(storeFunct3) << storeOffset);
        end
    end

    // The bus picks the right lanes via byteEn, so every lane carries a copy.
    always_comb begin
        case (storeFunct3)
            MEM_B:   wData = {(NB){storeData[7:0]}};
            MEM_H:   wData = {(NB / 2){storeData[15:0]}};
            MEM_W:   wData = {(NB / 4){storeData[31:0]}};
            default: wData = storeData;
        endcase
    end

    assign shifted = readData >> {loadOffset, 3'b000};

    always_comb begin
        case (loadFunct3)
            MEM_B:   loadData = XLEN'($signed(shifted[7:0]));
            MEM_H:   loadData = XLEN'($signed(shifted[15:0]));
            MEM_W:   loadData = XLEN'($signed(shifted[31:0]));
            MEM_BU:  loadData = XLEN'(shifted[7:0]);
            MEM_HU:  loadData = XLEN'(shifted[15:0]);
            MEM_WU:  loadData = XLEN'(shifted[31:0]);
            default: loadData = shifted;
        endcase
    end

endmodule

// File: rtl/stage_memory_lsu.sv
// Memory pipeline stage: issues loads/stores on a req/ack bus, stalls upstream
// while an access is outstanding and registers everything bound for writeback.
module stage_memory_lsu
    import riscv_mem_pkg::*;
#(
    parameter  int XLEN    = 32,
    parameter  int RD_W    = 5,
    parameter  int WBSRC_W = 2,
    localparam int NB      = XLEN / 8,
    localparam int OFFW    = $clog2(NB)
) (
    input  logic               i_Clock,
    input  logic               i_Reset,
    input  logic               i_Valid,
    output logic               o_Ready,
    input  logic               i_MemRead,
    input  logic               i_MemWrite,
    input  logic [2:0]         i_Funct3,
    input  logic [XLEN-1:0]    i_AluOutput,
    input  logic [XLEN-1:0]    i_Rs2Value,
    input  logic               i_RegWrite,
    input  logic [RD_W-1:0]    i_Rd,
    input  logic [WBSRC_W-1:0] i_WritebackSrc,
    output logic               o_MemReq,
    output logic               o_MemWe,
    output logic [XLEN-1:0]    o_MemAddr,
    output logic [XLEN-1:0]    o_MemWData,
    output logic [NB-1:0]      o_MemByteEn,
    input  logic               i_MemAck,
    input  logic [XLEN-1:0]    i_MemRData,
    output logic               o_Valid,
    output logic               o_RegWrite,
    output logic [RD_W-1:0]    o_Rd,
    output logic [WBSRC_W-1:0] o_WritebackSrc,
    output logic [XLEN-1:0]    o_AluOutput,
    output logic [XLEN-1:0]    o_MemoryData,
    output logic               o_MemFault
);

    lsu_state_e         state;
    logic               isMemOp;
    logic               fault;
    logic [NB-1:0]      alignByteEn;
    logic [XLEN-1:0]    alignWData;
    logic [XLEN-1:0]    alignLoadData;

    logic               reqLoad;
    logic [2:0]         reqFunct3;
    logic [OFFW-1:0]    reqOffset;
    logic               holdRegWrite;
    logic [RD_W-1:0]    holdRd;
    logic [WBSRC_W-1:0] holdWbSrc;
    logic [XLEN-1:0]    holdAlu;

    assign o_Ready = (state == IDLE);
    assign isMemOp = i_MemRead | i_MemWrite;

    // A simultaneous read and write has no meaning on this bus, so it faults.
    assign fault = isMemOp &&
                   ((i_MemRead && i_MemWrite) ||
                    !is_legal(i_Funct3, i_MemWrite, XLEN) ||
                    !is_aligned(i_Funct3, i_AluOutput[2:0], XLEN));

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .storeFunct3 (i_Funct3),
        .storeOffset (i_AluOutput[OFFW-1:0]),
        .isStore     (i_MemWrite),
        .storeData   (i_Rs2Value),
        .byteEn      (alignByteEn),
        .wData       (alignWData),
        .loadFunct3  (reqFunct3),
        .loadOffset  (reqOffset),
        .readData    (i_MemRData),
        .loadData    (alignLoadData)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state          <= IDLE;
            o_MemReq       <= 1'b0;
            o_MemWe        <= 1'b0;
            o_MemAddr      <= '0;
            o_MemWData     <= '0;
            o_MemByteEn    <= '0;
            reqLoad        <= 1'b0;
            reqFunct3      <= '0;
            reqOffset      <= '0;
            holdRegWrite   <= 1'b0;
            holdRd         <= '0;
            holdWbSrc      <= '0;
            holdAlu        <= '0;
            o_Valid        <= 1'b0;
            o_RegWrite     <= 1'b0;
            o_Rd           <= '0;
            o_WritebackSrc <= '0;
            o_AluOutput    <= '0;
            o_MemoryData   <= '0;
            o_MemFault     <= 1'b0;
        end else begin
            o_Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_Valid && isMemOp && !fault) begin
                        o_MemReq     <= 1'b1;
                        o_MemWe      <= i_MemWrite;
                        o_MemAddr    <= {i_AluOutput[XLEN-1:OFFW], {OFFW{1'b0}}};
                        o_MemWData   <= alignWData;
                        o_MemByteEn  <= alignByteEn;
                        reqLoad      <= i_MemRead;
                        reqFunct3    <= i_Funct3;
                        reqOffset    <= i_AluOutput[OFFW-1:0];
                        holdRegWrite <= i_RegWrite;
                        holdRd       <= i_Rd;
                        holdWbSrc    <= i_WritebackSrc;
                        holdAlu      <= i_AluOutput;
                        state        <= WAIT;
                    end else if (i_Valid) begin
                        o_Valid        <= 1'b1;
                        o_RegWrite     <= i_RegWrite & ~fault;
                        o_Rd           <= i_Rd;
                        o_WritebackSrc <= i_WritebackSrc;
                        o_AluOutput    <= i_AluOutput;
                        o_MemoryData   <= '0;
                        o_MemFault     <= fault;
                    end
                end
                WAIT: begin
                    // Bus outputs stay frozen until the cycle the ack arrives.
                    if (i_MemAck) begin
                        o_MemReq       <= 1'b0;
                        o_MemWe        <= 1'b0;
                        o_MemAddr      <= '0;
                        o_MemWData     <= '0;
                        o_MemByteEn    <= '0;
                        o_Valid        <= 1'b1;
                        o_RegWrite     <= holdRegWrite;
                        o_Rd           <= holdRd;
                        o_WritebackSrc <= holdWbSrc;
                        o_AluOutput    <= holdAlu;
                        o_MemoryData   <= reqLoad ? alignLoadData : '0;
                        o_MemFault     <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_memory_lsu.sv
// Scoreboard bench for stage_memory_lsu: directed and random instructions, a
// bus responder with random latency, and a monitor checking writeback results.
`timescale 1ns/1ps
module tb_stage_memory_lsu;

    localparam int XLEN = 32;
    localparam int RD_W = 5;
    localparam int WBSRC_W = 2;
    localparam int NB = XLEN / 8;

    logic               i_Clock = 1'b0;
    logic               i_Reset;
    logic               i_Valid;
    logic               o_Ready;
    logic               i_MemRead;
    logic               i_MemWrite;
    logic [2:0]         i_Funct3;
    logic [XLEN-1:0]    i_AluOutput;
    logic [XLEN-1:0]    i_Rs2Value;
    logic               i_RegWrite;
    logic [RD_W-1:0]    i_Rd;
    logic [WBSRC_W-1:0] i_WritebackSrc;
    logic               o_MemReq;
    logic               o_MemWe;
    logic [XLEN-1:0]    o_MemAddr;
    logic [XLEN-1:0]    o_MemWData;
    logic [NB-1:0]      o_MemByteEn;
    logic               i_MemAck;
    logic [XLEN-1:0]    i_MemRData;
    logic               o_Valid;
    logic               o_RegWrite;
    logic [RD_W-1:0]    o_Rd;
    logic [WBSRC_W-1:0] o_WritebackSrc;
    logic [XLEN-1:0]    o_AluOutput;
    logic [XLEN-1:0]    o_MemoryData;
    logic               o_MemFault;

    stage_memory_lsu #(.XLEN(XLEN), .RD_W(RD_W), .WBSRC_W(WBSRC_W)) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Valid(i_Valid), .o_Ready(o_Ready),
        .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_Funct3(i_Funct3),
        .i_AluOutput(i_AluOutput), .i_Rs2Value(i_Rs2Value), .i_RegWrite(i_RegWrite),
        .i_Rd(i_Rd), .i_WritebackSrc(i_WritebackSrc), .o_MemReq(o_MemReq),
        .o_MemWe(o_MemWe), .o_MemAddr(o_MemAddr), .o_MemWData(o_MemWData),
        .o_MemByteEn(o_MemByteEn), .i_MemAck(i_MemAck), .i_MemRData(i_MemRData),
        .o_Valid(o_Valid), .o_RegWrite(o_RegWrite), .o_Rd(o_Rd),
        .o_WritebackSrc(o_WritebackSrc), .o_AluOutput(o_AluOutput),
        .o_MemoryData(o_MemoryData), .o_MemFault(o_MemFault)
    );

    always #5 i_Clock = ~i_Clock;

    typedef struct {
        logic        regWrite;
        logic [4:0]  rd;
        logic [1:0]  wbSrc;
        logic [31:0] alu;
        logic [31:0] memData;
        logic        fault;
        int          stall;
    } result_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  byteEn;
        logic [31:0] wData;
        logic [31:0] rData;
        int          lat;
    } bus_t;

    result_t expQ[$];
    bus_t    busQ[$];
    int      assertCount = 0;
    int      failCount = 0;
    bit      respEnable = 1'b1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Reference load: pick the addressed bytes out of the word, then extend.
    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] word, input int off);
        int          bytes;
        logic [63:0] v;
        logic [63:0] mask;
        bytes = 1 << f3[1:0];
        v     = 64'(word) >> (8 * off);
        mask  = (64'd1 << (8 * bytes)) - 64'd1;
        v     = v & mask;
        if (!f3[2] && v[8 * bytes - 1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic bit modelFault(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
        int bytes;
        if (!rd && !wr) return 1'b0;
        if (rd && wr) return 1'b1;
        if (wr && f3 > 3'd2) return 1'b1;
        if (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        bytes = 1 << f3[1:0];
        return (a % bytes) != 0;
    endfunction

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge i_Clock);
            i_Valid = 1'b0;
        end
    endtask

    // Wait for o_Ready (driving ignored junk meanwhile), issue, and record expectations.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] rs2, input bit regW,
                                 input logic [4:0] rdIdx, input logic [1:0] wb,
                                 input logic [31:0] rData, input int lat, input bit track);
        int      guard;
        int      bytes;
        int      off;
        bit      flt;
        result_t r;
        bus_t    b;
        guard = 0;
        @(negedge i_Clock);
        while (!o_Ready) begin
            i_Valid     = 1'($urandom);
            i_MemRead   = 1'($urandom);
            i_MemWrite  = 1'($urandom);
            i_Funct3    = 3'($urandom);
            i_AluOutput = $urandom;
            guard++;
            if (guard > 100) begin
                timeoutFail("readyWait");
                return;
            end
            @(negedge i_Clock);
        end
        i_Valid = 1'b1;
        i_MemRead = rd;
        i_MemWrite = wr;
        i_Funct3 = f3;
        i_AluOutput = a;
        i_Rs2Value = rs2;
        i_RegWrite = regW;
        i_Rd = rdIdx;
        i_WritebackSrc = wb;
        if (!track) return;
        flt = modelFault(rd, wr, f3, a);
        bytes = 1 << f3[1:0];
        off = int'(a[1:0]);
        r.regWrite = regW && !flt;
        r.rd = rdIdx;
        r.wbSrc = wb;
        r.alu = a;
        r.fault = flt;
        r.memData = (rd && !flt) ? modelLoad(f3, rData, off) : 32'h0;
        r.stall = ((rd || wr) && !flt) ? lat + 1 : 0;
        expQ.push_back(r);
        if ((rd || wr) && !flt) begin
            b.addr = {a[31:2], 2'b00};
            b.we = wr;
            b.byteEn = wr ? 4'(((1 << bytes) - 1) << off) : 4'hF;
            b.wData = '0;
            for (int i = 0; i < 4; i++) b.wData[8 * i +: 8] = rs2[8 * (i % bytes) +: 8];
            b.rData = rData;
            b.lat = lat;
            busQ.push_back(b);
        end
    endtask

    // Bus responder: checks each request against the scoreboard and acks it.
    initial begin : responder
        bus_t         cur;
        bit           active;
        int           cnt;
        logic [68:0]  snap;
        active = 1'b0;
        cnt = 0;
        snap = '0;
        cur = '{default: '0};
        forever begin
            @(negedge i_Clock);
            if (!respEnable) continue;
            i_MemAck = 1'b0;
            i_MemRData = $urandom;
            if (o_MemReq) begin
                if (!active) begin
                    if (busQ.size() == 0) begin
                        checkOutput("unexpectedMemReq", 128'(o_MemReq), 128'(0));
                        cur = '{default: '0};
                    end else begin
                        cur = busQ.pop_front();
                        checkOutput("memAddr", 128'(o_MemAddr), 128'(cur.addr));
                        checkOutput("memWe", 128'(o_MemWe), 128'(cur.we));
                        checkOutput("memByteEn", 128'(o_MemByteEn), 128'(cur.byteEn));
                        if (cur.we) checkOutput("memWData", 128'(o_MemWData), 128'(cur.wData));
                    end
                    active = 1'b1;
                    cnt = cur.lat;
                    snap = {o_MemAddr, o_MemWe, o_MemByteEn, o_MemWData};
                end else begin
                    checkOutput("busStable", 128'({o_MemAddr, o_MemWe, o_MemByteEn, o_MemWData}), 128'(snap));
                end
                if (cnt == 0) begin
                    i_MemAck = 1'b1;
                    i_MemRData = cur.rData;
                    active = 1'b0;
                end else begin
                    cnt--;
                end
            end else begin
                if (active) begin
                    checkOutput("memReqDroppedEarly", 128'(o_MemReq), 128'(1));
                    active = 1'b0;
                end
                i_MemAck = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor: every o_Valid pops one expected result, including the stall it caused.
    initial begin : monitor
        result_t e;
        int      stall;
        stall = 0;
        forever begin
            @(negedge i_Clock);
            if (!o_Ready) stall++;
            if (o_Valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedValid", 128'(o_Valid), 128'(0));
                end else begin
                    e = expQ.pop_front();
                    checkOutput("regWrite", 128'(o_RegWrite), 128'(e.regWrite));
                    checkOutput("rd", 128'(o_Rd), 128'(e.rd));
                    checkOutput("wbSrc", 128'(o_WritebackSrc), 128'(e.wbSrc));
                    checkOutput("aluOutput", 128'(o_AluOutput), 128'(e.alu));
                    checkOutput("memoryData", 128'(o_MemoryData), 128'(e.memData));
                    checkOutput("memFault", 128'(o_MemFault), 128'(e.fault));
                    checkOutput("stallCycles", 128'(stall), 128'(e.stall));
                end
                stall = 0;
            end
        end
    end

    initial begin : watchdog
        #(200000 * 10);
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int          guard;
        bit          rd;
        bit          wr;
        int          kind;
        int          bytes;
        logic [2:0]  f3;
        logic [31:0] a;
        i_Reset = 1'b1;
        i_Valid = 1'b0;
        i_MemRead = 1'b0;
        i_MemWrite = 1'b0;
        i_Funct3 = '0;
        i_AluOutput = '0;
        i_Rs2Value = '0;
        i_RegWrite = 1'b0;
        i_Rd = '0;
        i_WritebackSrc = '0;
        i_MemAck = 1'b0;
        i_MemRData = '0;
        repeat (3) @(negedge i_Clock);
        checkOutput("resetReady", 128'(o_Ready), 128'(1));
        checkOutput("resetValid", 128'(o_Valid), 128'(0));
        checkOutput("resetMemReq", 128'(o_MemReq), 128'(0));
        checkOutput("resetByteEn", 128'(o_MemByteEn), 128'(0));
        checkOutput("resetMemAddr", 128'(o_MemAddr), 128'(0));
        checkOutput("resetMemoryData", 128'(o_MemoryData), 128'(0));
        checkOutput("resetAlu", 128'(o_AluOutput), 128'(0));
        checkOutput("resetFault", 128'(o_MemFault), 128'(0));
        checkOutput("resetRegWrite", 128'(o_RegWrite), 128'(0));
        i_Reset = 1'b0;

        applyStimulus(0, 0, 3'b000, 32'h0000_1234, 32'h0, 1, 5'd3, 2'd1, 32'h0, 0, 1);
        applyStimulus(1, 0, 3'b000, 32'h0000_1003, 32'h0, 1, 5'd4, 2'd2, 32'h80FF_FFFF, 3, 1);
        applyStimulus(0, 1, 3'b001, 32'h0000_2002, 32'hAABB_CCDD, 0, 5'd0, 2'd0, 32'h0, 1, 1);
        applyStimulus(1, 0, 3'b010, 32'h0000_3001, 32'h0, 1, 5'd7, 2'd2, 32'h0, 0, 1);
        applyStimulus(1, 0, 3'b101, 32'h0000_4002, 32'h0, 1, 5'd9, 2'd2, 32'h8001_FFFF, 0, 1);
        idleCycles(2);

        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            rd = (kind >= 3 && kind <= 6) || kind == 9;
            wr = (kind >= 7);
            f3 = 3'($urandom);
            a = $urandom;
            bytes = 1 << f3[1:0];
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(bytes) - 32'd1);
            applyStimulus(rd, wr, f3, a, $urandom, 1'($urandom), 5'($urandom), 2'($urandom),
                          $urandom, $urandom_range(0, 3), 1);
            if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 2));
        end
        idleCycles(1);

        guard = 0;
        while ((expQ.size() != 0 || busQ.size() != 0) && guard < 200) begin
            idleCycles(1);
            guard++;
        end
        if (guard >= 200) timeoutFail("drain");
        idleCycles(2);

        // Reset while a load is outstanding; the late ack must be ignored.
        respEnable = 1'b0;
        i_MemAck = 1'b0;
        applyStimulus(1, 0, 3'b010, 32'h0000_5000, 32'h0, 1, 5'd1, 2'd1, 32'h0, 0, 0);
        @(negedge i_Clock);
        i_Valid = 1'b0;
        checkOutput("t6ReqRaised", 128'(o_MemReq), 128'(1));
        checkOutput("t6Stalled", 128'(o_Ready), 128'(0));
        i_Reset = 1'b1;
        @(negedge i_Clock);
        i_Reset = 1'b0;
        checkOutput("t6ReqDropped", 128'(o_MemReq), 128'(0));
        checkOutput("t6ReadyAfterReset", 128'(o_Ready), 128'(1));
        @(negedge i_Clock);
        @(negedge i_Clock);
        i_MemAck = 1'b1;
        i_MemRData = $urandom;
        @(negedge i_Clock);
        i_MemAck = 1'b0;
        checkOutput("t6NoValid", 128'(o_Valid), 128'(0));
        checkOutput("t6NoReq", 128'(o_MemReq), 128'(0));
        checkOutput("t6Ready", 128'(o_Ready), 128'(1));
        @(negedge i_Clock);
        checkOutput("t6StillNoValid", 128'(o_Valid), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
